// File: rtl/ima_adpcm_decoder.sv
// IMA ADPCM decoder: rebuilds signed 16-bit PCM from 4-bit codes with a
// five-state shift-add datapath, one code accepted every 5 clocks.
module ima_adpcm_decoder #(
    parameter int                 INIT_INDEX = 0,
    parameter logic signed [15:0] INIT_PRED  = 16'sd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [3:0]         in_code,
    output logic               in_ready,
    output logic               out_valid,
    output logic signed [15:0] out_pcm,
    output logic [6:0]         out_index,
    output logic               overrun
);

    typedef enum logic [2:0] {S_IDLE, S_ACC2, S_ACC1, S_ACC0, S_APPLY} state_t;

    localparam logic [14:0] STEP_TBL [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    state_t             r_state, w_next;
    logic signed [15:0] r_pred;
    logic [6:0]         r_index;
    logic [3:0]         r_code;
    logic [14:0]        r_step;
    logic [16:0]        r_diff;
    logic               r_valid;
    logic               r_overrun;

    logic [14:0]        w_step;
    logic signed [7:0]  w_idx_delta;
    logic signed [7:0]  w_idx_sum;
    logic [6:0]         w_idx_sat;
    logic signed [17:0] w_sum;
    logic signed [15:0] w_pcm_sat;

    always_comb begin
        w_step = (r_index > 7'd88) ? 15'd32767 : STEP_TBL[r_index];
    end

    always_comb begin
        case (r_code[2:0])
            3'd4:    w_idx_delta = 8'sd2;
            3'd5:    w_idx_delta = 8'sd4;
            3'd6:    w_idx_delta = 8'sd6;
            3'd7:    w_idx_delta = 8'sd8;
            default: w_idx_delta = -8'sd1;
        endcase
        w_idx_sum = $signed({1'b0, r_index}) + w_idx_delta;
        if (w_idx_sum < 8'sd0)
            w_idx_sat = 7'd0;
        else if (w_idx_sum > 8'sd88)
            w_idx_sat = 7'd88;
        else
            w_idx_sat = w_idx_sum[6:0];
    end

    // 18 bits holds pred +/- 61436 without wrap, so clamping is exact
    always_comb begin
        if (r_code[3])
            w_sum = {{2{r_pred[15]}}, r_pred} - $signed({1'b0, r_diff});
        else
            w_sum = {{2{r_pred[15]}}, r_pred} + $signed({1'b0, r_diff});
        if (w_sum > 18'sd32767)
            w_pcm_sat = 16'sh7fff;
        else if (w_sum < -18'sd32768)
            w_pcm_sat = 16'sh8000;
        else
            w_pcm_sat = w_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else if (clear)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_ACC2;
            S_ACC2:  w_next = S_ACC1;
            S_ACC1:  w_next = S_ACC0;
            S_ACC0:  w_next = S_APPLY;
            S_APPLY: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred    <= INIT_PRED;
            r_index   <= 7'(INIT_INDEX);
            r_code    <= '0;
            r_step    <= '0;
            r_diff    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_pred    <= INIT_PRED;
            r_index   <= 7'(INIT_INDEX);
            r_code    <= '0;
            r_step    <= '0;
            r_diff    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (in_valid && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_code <= in_code;
                    r_step <= w_step;
                    r_diff <= 17'(w_step >> 3);
                end
                S_ACC2:  if (r_code[2]) r_diff <= r_diff + 17'(r_step);
                S_ACC1:  if (r_code[1]) r_diff <= r_diff + 17'(r_step >> 1);
                S_ACC0:  if (r_code[0]) r_diff <= r_diff + 17'(r_step >> 2);
                S_APPLY: begin
                    r_pred  <= w_pcm_sat;
                    r_index <= w_idx_sat;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_valid;
    assign out_pcm   = r_pred;
    assign out_index = r_index;
    assign overrun   = r_overrun;

endmodule

// File: doc/ima_adpcm_decoder.md
Name: ima_adpcm_decoder

Overview:
- Loopback/monitor decoder that sits directly downstream of the CIC + ADPCM compressor.
- Consumes the 4-bit IMA ADPCM codes the compressor emits (one code per valid strobe).
- Reconstructs signed 16-bit PCM so the encoded stream can be checked on-chip or driven out.
- Multi-cycle shift-add datapath with a small FSM; one code is decoded every 5 clocks.

Parameters:
- INIT_INDEX, 0: step-index value loaded on reset and on clear; legal range 0..88.
- INIT_PRED, 0: signed 16-bit predictor value loaded on reset and on clear.

Ports:
- clk  input  1  system clock, same clock that samples the compressor's valid strobe.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear: predictor and index reload, FSM to IDLE, overrun cleared.
- in_valid  input  1  code strobe from the compressor (its outValid).
- in_code  input  4  ADPCM code; bit3 = sign, bits2..0 = magnitude.
- in_ready  output  1  high only in IDLE.
- out_valid  output  1  one-cycle pulse when out_pcm updates.
- out_pcm  output  16  signed reconstructed sample (registered predictor).
- out_index  output  7  current step index, 0..88.
- overrun  output  1  sticky flag: a code arrived while the block was busy.

Behaviour:
- Reset (async, rst_n=0) sets:
  - out_pcm=INIT_PRED, out_index=INIT_INDEX.
  - out_valid=0, overrun=0, FSM=IDLE.
  - All datapath registers to 0.
- Step table: standard 89-entry IMA/DVI table, index 0..88 maps to 7,8,9,10,11,12,13,14,16,17,...,29794,32767. It is a combinational ROM.
- Index table for code[2:0]=0..7: -1,-1,-1,-1,+2,+4,+6,+8.
- FSM states, one clock each, run in this order:
  - IDLE: in_ready=1. On in_valid=1:
    - latch code;
    - step_r = table[index];
    - diff_r = step_r>>3 (computed from the ROM output);
    - go to ACC2.
  - ACC2: if code[2], diff_r += step_r. Go to ACC1.
  - ACC1: if code[1], diff_r += step_r>>1. Go to ACC0.
  - ACC0: if code[0], diff_r += step_r>>2. Go to APPLY.
  - APPLY:
    - sum = pred - diff_r if code[3], else pred + diff_r.
    - sum is computed at 18-bit signed width; diff_r is 17-bit unsigned, maximum 61436.
    - Saturate sum to [-32768, 32767] and store it in pred.
    - index += idx_tbl[code[2:0]], saturated to [0, 88].
    - Set out_valid=1 and go to IDLE.
- out_valid is high for exactly one cycle, the cycle after APPLY. It coincides with IDLE, so a new code may be accepted in that same cycle.
- Latency: the accepting edge is E0. out_pcm/out_index update and out_valid rises on E4. That is 4 edges, 5-clock throughput.
- in_valid while the FSM is not IDLE:
  - the code is dropped;
  - overrun is set to 1 and stays set until rst_n or clear;
  - the decode in progress completes unaffected.
- in_valid held high in IDLE is treated as a new code each time the FSM returns to IDLE. Upstream pulses are single-cycle by contract.
- clear has priority over every FSM action:
  - any in-progress decode is aborted with no out_valid;
  - in_valid in the same cycle is ignored.
- Asynchronous reset mid-decode:
  - outputs go immediately to reset values;
  - no out_valid is produced for the aborted code.
- Index boundaries:
  - index 0 with code magnitude 0..3 stays 0;
  - index 88 with code magnitude 4..7 stays 88.
- Predictor boundaries: an overflow in either direction clamps the output and never wraps.

Test Plan:
- Reset defaults; one pulse code=0x4:
  - out_valid exactly 4 edges after the accept;
  - out_pcm=7, out_index=2;
  - in_ready low for 4 cycles.
- From reset, code=0x7 → out_pcm=11, out_index=8. Then code=0xF → diff = step[8]=16 >>3 = 2, +16, +8, +4 = 30; out_pcm=-19, out_index=16.
- From reset, code=0x0 → out_pcm=0 (diff 0), out_index stays 0 (floor clamp). Code=0x8 gives the same result.
- INIT_INDEX=88:
  - code=0x7 repeated 3× → diff=61436, out_pcm=32767 each time, out_index=88;
  - then 0xF repeated 3× → out_pcm=-28669 then -32768 (clamped), out_index=88.
- Pulse in_valid during ACC1 → overrun=1, code dropped, exactly one out_valid. Then clear → overrun=0, out_pcm=INIT_PRED, out_index=INIT_INDEX.
- Assert rst_n=0 during ACC0 → outputs at reset values immediately, no out_valid. After release, code=0x4 decodes to out_pcm=7.
